// File: rtl/radix4_seq_lpm_pkg.sv
// Package lpm_pkg: shared types and constants for the radix-4 sequential
// low-power multiplier.
//   state_e  : FSM encoding (IDLE, RUN, DONE)
//   DIG_*    : radix-4 multiplier digit codes
//   clog2    : ceiling log2, used to size the digit index counter
package lpm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_B    = 2'b01;
  localparam logic [1:0] DIG_2B   = 2'b10;
  localparam logic [1:0] DIG_3B   = 2'b11;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/radix4_seq_lpm_digit_decoder.sv
// lpm_digit_decoder: combinational radix-4 digit decoder.
// Ports:
//   d     in   2    current multiplier digit
//   b     in   N    multiplicand
//   b3    in   N+2  precomputed 3*b
//   sel   out  4    one-hot select (bit0=0, bit1=B, bit2=2B, bit3=3B)
//   pp    out  N+2  selected partial product
//   pp_nz out  1    accumulator enable; low for a zero digit
module lpm_digit_decoder
  import lpm_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [1:0]   d,
  input  logic [N-1:0] b,
  input  logic [N+1:0] b3,
  output logic [3:0]   sel,
  output logic [N+1:0] pp,
  output logic         pp_nz
);

  always_comb begin
    sel = '0;
    pp  = '0;
    case (d)
      DIG_ZERO: sel[0] = 1'b1;
      DIG_B: begin
        sel[1] = 1'b1;
        pp     = {2'b00, b};
      end
      DIG_2B: begin
        sel[2] = 1'b1;
        pp     = {1'b0, b, 1'b0};
      end
      DIG_3B: begin
        sel[3] = 1'b1;
        pp     = b3;
      end
      default: sel = '0;
    endcase
  end

  assign pp_nz = ~sel[0];

endmodule

// File: rtl/radix4_seq_lpm.sv
// radix4_seq_lpm: sequential radix-4 unsigned multiplier, one 2-bit digit
// of a per cycle, behind a start/ready/done handshake.
// Ports:
//   clk     in   1   clock, rising edge
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   request, accepted when ready=1
//   a       in   N   multiplier, sampled on accept
//   b       in   N   multiplicand, sampled on accept
//   ready   out  1   idle, can accept start
//   busy    out  1   multiplication in progress
//   done    out  1   one-cycle pulse, product valid
//   product out  2N  a*b, held until the next accept
// Build option: define LPM_EARLY_TERM_EN to leave RUN as soon as the
// remaining multiplier digits are all zero (same product, shorter latency).
module radix4_seq_lpm
  import lpm_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  if ((N % 2) != 0 || N < 4) begin : g_bad_n
    $error("radix4_seq_lpm: N must be even and >= 4");
  end

  localparam int unsigned KW = (clog2(N/2) < 1) ? 1 : clog2(N/2);
  localparam logic [KW-1:0] K_LAST = KW'(N/2 - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    a_sh_q, a_sh_d;
  logic [N-1:0]    b_q, b_d;
  logic [N+1:0]    b3_q, b3_d;
  logic [KW-1:0]   k_q, k_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [2*N-1:0]  product_q, product_d;

  logic [3:0]      sel;
  logic [N+1:0]    pp;
  logic            pp_nz;
  logic [2*N-1:0]  acc_sum;
  logic            last_digit;

  lpm_digit_decoder #(.N(N)) u_dec (
    .d     (a_sh_q[1:0]),
    .b     (b_q),
    .b3    (b3_q),
    .sel   (sel),
    .pp    (pp),
    .pp_nz (pp_nz)
  );

  assign acc_sum = acc_q + ({{(N-2){1'b0}}, pp} << {k_q, 1'b0});

`ifdef LPM_EARLY_TERM_EN
  assign last_digit = ((a_sh_q >> 2) == '0);
`else
  assign last_digit = (k_q == K_LAST);
`endif

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_d       = b_q;
    b3_d      = b3_q;
    k_d       = k_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_d     = b;
          b3_d    = {2'b00, b} + {1'b0, b, 1'b0};
          k_d     = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 2;
        k_d    = k_q + 1'b1;
        // Zero digit: accumulator is left untouched so it does not toggle.
        if (pp_nz) acc_d = acc_sum;
        if (last_digit) begin
          state_d   = DONE;
          product_d = (|sel[3:1]) ? acc_sum : acc_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_q       <= '0;
      b3_q      <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_q       <= b_d;
      b3_q      <= b3_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_radix4_seq_lpm.sv
// Scoreboard bench for radix4_seq_lpm (N=8). The driver pushes the
// expected product and done latency at each accept; a negedge monitor pops
// and compares whenever done is high. Latency is counted in cycles where
// the cycle right after the accept edge is cycle 1.
module tb_radix4_seq_lpm;

  localparam int unsigned N = 8;

`ifdef LPM_EARLY_TERM_EN
  localparam int unsigned LAT_FF = 5, LAT_03 = 2, LAT_00 = 2, LAT_12 = 4,
                          LAT_0F = 3, LAT_05 = 3;
`else
  localparam int unsigned LAT_FF = 5, LAT_03 = 5, LAT_00 = 5, LAT_12 = 5,
                          LAT_0F = 5, LAT_05 = 5;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   a, b;
  logic           ready, busy, done;
  logic [2*N-1:0] product;

  radix4_seq_lpm #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*N-1:0] p;
    int unsigned    lat;
    int unsigned    t0;
    string          nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  bit   chk_ppnz = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check({e.nm, "_product"}, 64'(product), 64'(e.p));
          check({e.nm, "_latency"}, 64'(cyc - e.t0 + 1), 64'(e.lat));
          check({e.nm, "_ready_in_done"}, 64'(ready), 64'd0);
        end
      end
      if (busy && chk_ppnz) check("pp_nz_zero_digit", 64'(dut.u_dec.pp_nz), 64'd0);
    end
  end

  task automatic push_exp(input logic [2*N-1:0] p, input int unsigned lat, input string nm);
    exp_t x;
    x.p = p; x.lat = lat; x.t0 = cyc; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic [2*N-1:0] p, input int unsigned lat, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check({nm, "_ready_timeout"}, 64'd0, 64'd1);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    push_exp(p, lat, nm);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || !ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check({nm, "_done_timeout"}, 64'd0, 64'd1);
      sb.delete();
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_ready", 64'(ready), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("idle_product", 64'(product), 64'd0);
    end

    issue(8'hFF, 8'hFF, 16'hFE01, LAT_FF, "ff_ff");
    wait_idle("ff_ff");
    repeat (3) @(negedge clk);
    check("ff_ff_hold", 64'(product), 64'hFE01);

    issue(8'h03, 8'hFF, 16'h02FD, LAT_03, "03_ff");
    wait_idle("03_ff");

    chk_ppnz = 1'b1;
    issue(8'h00, 8'hAB, 16'h0000, LAT_00, "00_ab");
    wait_idle("00_ab");
    chk_ppnz = 1'b0;

    // Back-to-back with start held high throughout
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    push_exp(16'h03A8, LAT_12, "b2b_first");
    a = 8'h0F; b = 8'h0E;
    @(negedge clk);
    check("b2b_busy_ignores_start", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("b2b_done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    check("b2b_idle_ready", 64'(ready), 64'd1);
    @(posedge clk); #1;
    push_exp(16'h00D2, LAT_0F, "b2b_second");
    @(negedge clk);
    start = 1'b0;
    wait_idle("b2b");

    // Reset in the 2nd RUN cycle
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #2;
    check("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_abort_product", 64'(product), 64'd0);

    issue(8'h05, 8'h07, 16'h0023, LAT_05, "05_07");
    wait_idle("05_07");
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
